// File: rtl/sbox_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sbox_rr_arbiter
//
// Shares one combinational AES forward S-box between NREQ byte requesters.
// Requesters are granted round-robin over valid/ready handshakes. A granted
// byte is registered in stage A, pushed through the S-box into stage B, and
// returned from stage B tagged with the index of the requester that sent it.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : [NREQ] per-requester request valid
//   req_ready  : [NREQ] per-requester accept (at most one bit high)
//   req_data   : [8*NREQ] byte i is req_data[8*i+7:8*i]
//   rsp_valid  : result valid (stage B valid)
//   rsp_ready  : consumer accepts the result
//   rsp_data   : [8] S-box output byte
//   rsp_id     : [IDW] index of the requester that supplied the byte
//   occupancy  : [2] number of valid pipeline stages (0..2)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// complex_circuit
//
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (polynomial x^8+x^4+x^3+x+1, inverse of 0 taken as 0) followed by the AES
// affine transform.
//
// Ports
//   U : [8] input byte
//   R : [8] substituted byte
// ---------------------------------------------------------------------------
module complex_circuit (
    input  logic [7:0] U,
    output logic [7:0] R
);

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // x^254 is the inverse in GF(2^8) and maps 0 to 0 without a special case.
    // It is built as the product x^2 * x^4 * ... * x^128.
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] result;
        logic [7:0] sq;
        result = 8'h01;
        sq     = x;
        for (int i = 1; i < 8; i++) begin
            sq     = gfMul(sq, sq);
            result = gfMul(result, sq);
        end
        return result;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv = gfInv(U);
        R     = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ 8'h63;
    end

endmodule

module sbox_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic [1:0]        occupancy
);

    logic           r_aValid;
    logic [7:0]     r_aData;
    logic [IDW-1:0] r_aId;
    logic           r_bValid;
    logic [7:0]     r_bData;
    logic [IDW-1:0] r_bId;
    logic [IDW-1:0] r_ptr;

    logic           w_bFree;
    logic           w_aFree;
    logic           w_anyValid;
    logic [IDW-1:0] w_gnt;
    logic           w_accept;
    logic           w_aToB;
    logic [7:0]     w_sboxOut;
    logic [IDW:0]   w_idx;

    // The only S-box instance; it sits between the A and B registers so its
    // logic depth never touches the request or response ports.
    complex_circuit u_sbox (
        .U (r_aData),
        .R (w_sboxOut)
    );

    // A stage can take new data when it is empty or when its content moves on
    // this cycle; the same holds for B with the consumer as its sink.
    always_comb begin
        w_bFree = !r_bValid || rsp_ready;
        w_aFree = !r_aValid || w_bFree;
        w_aToB  = r_aValid && w_bFree;
    end

    // Round-robin search starting at the pointer. The index is computed one
    // bit wider than the ID so that ptr+k can be folded back below NREQ even
    // when NREQ is not a power of two.
    always_comb begin
        w_gnt      = '0;
        w_anyValid = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_anyValid && req_valid[w_idx[IDW-1:0]]) begin
                w_anyValid = 1'b1;
                w_gnt      = w_idx[IDW-1:0];
            end
        end
    end

    // Only the granted requester sees ready, and nobody does during reset.
    always_comb begin
        req_ready = '0;
        w_accept  = w_anyValid && w_aFree && !rst;
        if (!rst && w_anyValid) req_ready[w_gnt] = w_aFree;
    end

    // Stage A and the priority pointer. A new accept overrides the clear that
    // a transfer into B would otherwise cause, giving full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aValid <= 1'b0;
            r_aData  <= 8'h00;
            r_aId    <= '0;
            r_ptr    <= '0;
        end else if (w_accept) begin
            r_aValid <= 1'b1;
            r_aData  <= req_data[{w_gnt, 3'b000} +: 8];
            r_aId    <= w_gnt;
            r_ptr    <= (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + IDW'(1);
        end else if (w_aToB) begin
            r_aValid <= 1'b0;
        end
    end

    // Stage B captures the S-box result. When it is stalled (valid and the
    // consumer not ready) nothing here changes, so the response holds stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bValid <= 1'b0;
            r_bData  <= 8'h00;
            r_bId    <= '0;
        end else if (w_aToB) begin
            r_bValid <= 1'b1;
            r_bData  <= w_sboxOut;
            r_bId    <= r_aId;
        end else if (rsp_ready) begin
            r_bValid <= 1'b0;
        end
    end

    always_comb begin
        rsp_valid = r_bValid;
        rsp_data  = r_bData;
        rsp_id    = r_bId;
        occupancy = {1'b0, r_aValid} + {1'b0, r_bValid};
    end

endmodule

// File: tb/tb_sbox_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sbox_rr_arbiter
//
// Self-checking bench for sbox_rr_arbiter with NREQ=4. Directed phases run
// from a table of per-cycle vectors; random phases are compared against a
// queue-based model of the two-deep pipeline and an S-box computed by brute
// force inversion in GF(2^8).
// ---------------------------------------------------------------------------
module tb_sbox_rr_arbiter;

    localparam int NREQ = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    sbox_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .occupancy (occupancy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something unforeseen stalls the stimulus.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference S-box: GF(2^8) multiply by shift-and-add, inverse found by
    // searching all candidates, then the affine map written bit by bit.
    function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 0) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] refSbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] c   = 8'h63;
        logic [7:0] s;
        for (int b = 1; b < 256; b++)
            if (x != 0 && refMul(x, 8'(b)) == 8'h01) inv = 8'(b);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                 ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r);
        req_valid = v;
        rsp_ready = r;
    endtask

    // -----------------------------------------------------------------------
    // Directed vector tables
    // -----------------------------------------------------------------------
    typedef struct {
        logic [3:0] reqValid;
        logic       rspReady;
        logic [3:0] expReady;
        logic       expRspValid;
        logic [7:0] expData;
        logic [1:0] expId;
        logic [1:0] expOcc;
    } vec_t;

    vec_t vecs[$];

    // Each row is driven at a falling edge, checked 1 ns later, and the
    // following rising edge acts on it.
    task automatic runTable(input int first, input int count, input string tag);
        for (int n = first; n < first + count; n++) begin
            applyStimulus(vecs[n].reqValid, vecs[n].rspReady);
            #1;
            checkVal($sformatf("%s[%0d] req_ready", tag, n), 32'(req_ready), 32'(vecs[n].expReady));
            checkVal($sformatf("%s[%0d] rsp_valid", tag, n), 32'(rsp_valid), 32'(vecs[n].expRspValid));
            checkVal($sformatf("%s[%0d] occupancy", tag, n), 32'(occupancy), 32'(vecs[n].expOcc));
            if (vecs[n].expRspValid) begin
                checkVal($sformatf("%s[%0d] rsp_data", tag, n), 32'(rsp_data), 32'(vecs[n].expData));
                checkVal($sformatf("%s[%0d] rsp_id", tag, n), 32'(rsp_id), 32'(vecs[n].expId));
            end
            @(negedge clk);
        end
    endtask

    // Reset raised and dropped away from both clock edges; outputs are
    // checked while reset is still high, with every requester asking.
    task automatic pulseReset(input string tag);
        req_valid = 4'hF;
        #3 rst = 1'b1;
        #1;
        checkVal({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkVal({tag, " occupancy"}, 32'(occupancy), 32'd0);
        checkVal({tag, " req_ready"}, 32'(req_ready), 32'd0);
        checkVal({tag, " rsp_data"}, 32'(rsp_data), 32'h00);
        checkVal({tag, " rsp_id"}, 32'(rsp_id), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: a queue of in-flight bytes, oldest first. The oldest
    // entry is visible to the consumer once it has spent one edge in flight.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
        bit         atOut;
    } item_t;

    item_t pipe[$];
    int    modelPtr;

    task automatic modelReset();
        pipe.delete();
        modelPtr = 0;
    endtask

    task automatic modelGrant(output int g, output bit any);
        g   = 0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx = (modelPtr + k) % NREQ;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        int         g;
        bit         any;
        bit         expValid;
        logic [3:0] expReady;
        modelGrant(g, any);
        expValid = (pipe.size() > 0) && pipe[0].atOut;
        expReady = 4'h0;
        if (any && (pipe.size() < 2 || rsp_ready)) expReady[g] = 1'b1;
        checkVal({tag, " req_ready"}, 32'(req_ready), 32'(expReady));
        checkVal({tag, " rsp_valid"}, 32'(rsp_valid), 32'(expValid));
        checkVal({tag, " occupancy"}, 32'(occupancy), 32'(pipe.size()));
        if (expValid) begin
            checkVal({tag, " rsp_data"}, 32'(rsp_data), 32'(pipe[0].data));
            checkVal({tag, " rsp_id"}, 32'(rsp_id), 32'(pipe[0].id));
        end
    endtask

    // One clock of model-checked operation; inputs are already driven.
    task automatic cycleModel(input string tag, output bit accepted);
        int    g;
        bit    any;
        bit    drain;
        item_t it;
        #1;
        checkOutput(tag);
        modelGrant(g, any);
        accepted = any && (pipe.size() < 2 || rsp_ready);
        drain    = (pipe.size() > 0) && pipe[0].atOut && rsp_ready;
        it.data  = refSbox(req_data[8*g +: 8]);
        it.id    = 2'(g);
        it.atOut = 1'b0;
        @(posedge clk);
        if (drain) void'(pipe.pop_front());
        if (pipe.size() > 0) pipe[0].atOut = 1'b1;
        if (accepted) begin
            pipe.push_back(it);
            modelPtr = (g + 1) % NREQ;
        end
        @(negedge clk);
    endtask

    task automatic drainModel(input string tag);
        bit acc;
        applyStimulus(4'h0, 1'b1);
        for (int n = 0; n < 4; n++) cycleModel(tag, acc);
    endtask

    initial begin
        bit         acc;
        int         sent;
        int         cyc;
        int         r;
        logic [7:0] lanes[4];

        // Round robin: all valid, responses at one per cycle.
        vecs.push_back('{4'hF, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back('{4'hF, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 2'd1});
        vecs.push_back('{4'hF, 1'b1, 4'b0100, 1'b1, 8'h63, 2'd0, 2'd2});
        vecs.push_back('{4'hF, 1'b1, 4'b1000, 1'b1, 8'h7C, 2'd1, 2'd2});
        vecs.push_back('{4'hF, 1'b1, 4'b0001, 1'b1, 8'hED, 2'd2, 2'd2});
        vecs.push_back('{4'hF, 1'b1, 4'b0010, 1'b1, 8'h16, 2'd3, 2'd2});
        vecs.push_back('{4'hF, 1'b1, 4'b0100, 1'b1, 8'h63, 2'd0, 2'd2});
        vecs.push_back('{4'hF, 1'b1, 4'b1000, 1'b1, 8'h7C, 2'd1, 2'd2});
        // Stall with a full pipe: nobody ready, response held.
        vecs.push_back('{4'hF, 1'b0, 4'b0000, 1'b1, 8'hED, 2'd2, 2'd2});
        vecs.push_back('{4'h0, 1'b0, 4'b0000, 1'b1, 8'hED, 2'd2, 2'd2});
        // After mid-operation reset: no stale response, requester 0 wins,
        // its 0x00 comes back as 0x63 two cycles later.
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back('{4'hF, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd1});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 8'h63, 2'd0, 2'd1});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0});
        // Wrap-around with requesters 1 and 3: grants 1,3,1,3.
        vecs.push_back('{4'hA, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back('{4'hA, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0, 2'd1});
        vecs.push_back('{4'hA, 1'b1, 4'b0010, 1'b1, 8'h7C, 2'd1, 2'd2});
        vecs.push_back('{4'hA, 1'b1, 4'b1000, 1'b1, 8'h16, 2'd3, 2'd2});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 8'h7C, 2'd1, 2'd2});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 8'h16, 2'd3, 2'd1});
        vecs.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 2'd0});

        // Power-up reset, checked before any clock edge.
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_data  = {8'hFF, 8'h53, 8'h01, 8'h00};
        #3;
        checkVal("por req_ready", 32'(req_ready), 32'd0);
        checkVal("por rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("por occupancy", 32'(occupancy), 32'd0);
        checkVal("por rsp_data", 32'(rsp_data), 32'h00);
        checkVal("por rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);

        runTable(0, 10, "rr");
        pulseReset("midrst");
        runTable(10, 13, "wrap");

        // Backpressure: ten bytes from requester 2, consumer stalls 5 cycles.
        pulseReset("bp rst");
        modelReset();
        sent = 0;
        cyc  = 0;
        while ((sent < 10 || pipe.size() > 0) && cyc < 100) begin
            req_data[23:16] = 8'($urandom);
            applyStimulus((sent < 10) ? 4'b0100 : 4'b0000, !(cyc >= 3 && cyc < 8));
            cycleModel("bp", acc);
            if (acc) sent++;
            cyc++;
        end
        if (cyc >= 100) begin
            fails++;
            $display("[TB] FAIL bp timeout: sent %0d, expected 10", sent);
        end

        // Random traffic from all requesters with random consumer stalls.
        for (int n = 0; n < 400; n++) begin
            req_data = $urandom;
            applyStimulus(4'($urandom), ($urandom_range(0, 9) < 7));
            cycleModel("rand", acc);
        end
        drainModel("rand drain");

        // Every input byte, each from a random requester, random rsp_ready.
        for (int v = 0; v < 256; v++) begin
            r = $urandom_range(0, 3);
            for (int l = 0; l < 4; l++) lanes[l] = 8'($urandom);
            lanes[r] = 8'(v);
            req_data = {lanes[3], lanes[2], lanes[1], lanes[0]};
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 64) begin
                applyStimulus(4'(1 << r), 1'($urandom));
                cycleModel("exh", acc);
                cyc++;
            end
            if (!acc) begin
                fails++;
                $display("[TB] FAIL exh accept timeout: byte 0x%0h not accepted", v);
            end
        end
        drainModel("exh drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
